// File: rtl/relay_pkg.sv
// Shared codes for the 13.56 MHz relay framer: mod_type/role codes,
// start/end-of-communication patterns and the framer FSM states.
package relay_pkg;

    typedef enum logic [2:0] {
        SNIFFER       = 3'b000,
        TAGSIM_LISTEN = 3'b001,
        TAGSIM_MOD    = 3'b010,
        READER_LISTEN = 3'b011,
        READER_MOD    = 3'b100,
        FAKE_READER   = 3'b101,
        FAKE_TAG      = 3'b110
    } mod_type_e;

    typedef enum logic [1:0] {
        ROLE_PASSTHRU = 2'd0,
        ROLE_READER   = 2'd1,
        ROLE_TAG      = 2'd2
    } role_e;

    typedef enum logic {
        LISTEN = 1'b0,
        MOD    = 1'b1
    } state_e;

    localparam logic [23:0] READER_START = 24'h0000C0;
    localparam logic [23:0] READER_END_A = 24'h000000;
    localparam logic [23:0] READER_END_B = 24'hC00000;
    localparam logic [23:0] TAG_START    = 24'h0000F0;
    localparam logic [15:0] TAG_END      = 16'h0000;

    function automatic role_e decode_role(input logic [2:0] mode);
        if (mode == FAKE_READER)
            return ROLE_READER;
        else if (mode == FAKE_TAG)
            return ROLE_TAG;
        else
            return ROLE_PASSTHRU;
    endfunction

endpackage

// File: rtl/relay_frame_ctrl_tick_gen.sv
// relay_tick_gen: free-running 2^DIV_W divider that raises tick for one
// clock whenever the count equals DIV_PHASE.
module relay_tick_gen #(
    parameter int DIV_W     = 4,
    parameter int DIV_PHASE = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == DIV_PHASE[DIV_W-1:0]);

endmodule

// File: rtl/relay_frame_ctrl.sv
// Relay-link framer: samples relay_in on sub-carrier ticks, detects frame
// start/end for the fake reader/tag roles and drives mod_type for
// hi_iso14443a. Optional completed-frame counter under RELAY_FRAME_CNT_EN.
module relay_frame_ctrl
    import relay_pkg::*;
#(
    parameter int DIV_W     = 4,
    parameter int DIV_PHASE = 8,
    parameter int HIST_W    = 24,
    parameter int DATA_TAP  = 7,
    parameter int MAX_BYTES = 64
) (
    input  logic        ck_1356meg,
    input  logic        rst,
    input  logic [2:0]  mode_i,
    input  logic        relay_in,
    output logic [2:0]  mod_type_o,
    output logic        data_o,
    output logic        frame_active_o,
    output logic        byte_strobe_o,
    output logic        timeout_err_o
`ifdef RELAY_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt_o
`endif
);

    logic              tick;
    role_e             role;
    role_e             role_q;
    logic              role_chg;
    state_e            state;
    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_shift;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_inc;
    logic [7:0]        byte_cnt;
    logic [7:0]        byte_inc;
    logic              start_hit;
    logic              end_hit;
    logic              wrap;
    logic              shift_en;
    logic              end_evt;
    logic              timeout_evt;
    logic              unused_hist_msb;

    relay_tick_gen #(
        .DIV_W     (DIV_W),
        .DIV_PHASE (DIV_PHASE)
    ) u_tick (
        .clk  (ck_1356meg),
        .rst  (rst),
        .tick (tick)
    );

    assign role     = decode_role(mode_i);
    assign role_chg = (role != role_q);

    assign hist_shift      = {hist[HIST_W-2:0], relay_in};
    assign unused_hist_msb = hist[HIST_W-1];
    assign bit_inc         = bit_cnt + 3'd1;
    assign byte_inc        = byte_cnt + 8'd1;
    assign wrap            = (bit_inc == 3'd0);
    assign shift_en        = tick && !role_chg && (role != ROLE_PASSTHRU);

    // Patterns are judged on the history as it will look after this tick's shift.
    always_comb begin
        start_hit = 1'b0;
        end_hit   = 1'b0;
        if (role == ROLE_READER) begin
            start_hit = (hist_shift[23:0] == READER_START);
            end_hit   = (hist_shift[23:0] == READER_END_A) ||
                        (hist_shift[23:0] == READER_END_B);
        end else if (role == ROLE_TAG) begin
            start_hit = (hist_shift[23:0] == TAG_START);
            end_hit   = (hist_shift[15:0] == TAG_END);
        end
    end

    // A start pattern inside a frame re-arms it and pre-empts end/timeout.
    assign end_evt     = shift_en && (state == MOD) && !start_hit && wrap && end_hit;
    assign timeout_evt = shift_en && (state == MOD) && !start_hit && wrap && !end_hit &&
                         (byte_inc == 8'(MAX_BYTES));

    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state         <= LISTEN;
            role_q        <= role;
            hist          <= '0;
            bit_cnt       <= 3'd0;
            byte_cnt      <= 8'd0;
            byte_strobe_o <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            role_q        <= role;
            byte_strobe_o <= 1'b0;
            timeout_err_o <= 1'b0;
            if (role_chg) begin
                state    <= LISTEN;
                hist     <= '0;
                bit_cnt  <= 3'd0;
                byte_cnt <= 8'd0;
            end else if (role == ROLE_PASSTHRU) begin
                state <= LISTEN;
            end else if (shift_en) begin
                hist    <= hist_shift;
                bit_cnt <= bit_inc;
                case (state)
                    LISTEN: begin
                        if (start_hit) begin
                            state    <= MOD;
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 8'd0;
                        end
                    end
                    MOD: begin
                        if (start_hit) begin
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 8'd0;
                        end else if (wrap) begin
                            byte_strobe_o <= 1'b1;
                            byte_cnt      <= byte_inc;
                            if (end_evt) begin
                                state <= LISTEN;
                            end else if (timeout_evt) begin
                                state         <= LISTEN;
                                timeout_err_o <= 1'b1;
                            end
                        end
                    end
                    default: state <= LISTEN;
                endcase
            end
        end
    end

    // During a relay-to-relay swap the old role's MOD state is stale for one clock.
    always_comb begin
        mod_type_o = mode_i;
        if (role == ROLE_READER)
            mod_type_o = ((state == MOD) && !role_chg) ? READER_MOD : READER_LISTEN;
        else if (role == ROLE_TAG)
            mod_type_o = ((state == MOD) && !role_chg) ? TAGSIM_MOD : TAGSIM_LISTEN;
    end

    assign data_o         = hist[DATA_TAP];
    assign frame_active_o = (state == MOD);

`ifdef RELAY_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge ck_1356meg) begin
        if (rst)
            frame_cnt_q <= 16'd0;
        else if (end_evt && (frame_cnt_q != 16'hFFFF))
            frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_relay_frame_ctrl.sv
// Scoreboard bench for relay_frame_ctrl: stimulus queues expected output
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_relay_frame_ctrl;

    localparam int MAX_BYTES = 4;
    localparam logic [1:0] EV_MOD = 2'd0;
    localparam logic [1:0] EV_STB = 2'd1;
    localparam logic [1:0] EV_TMO = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode_i;
    logic        relay_in;
    logic [2:0]  mod_type_o;
    logic        data_o;
    logic        frame_active_o;
    logic        byte_strobe_o;
    logic        timeout_err_o;
`ifdef RELAY_FRAME_CNT_EN
    logic [15:0] frame_cnt_o;
`endif

    ev_t        expq[$];
    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;
    logic [2:0] prev_mod;

    always #5 clk = ~clk;

    relay_frame_ctrl #(
        .DIV_W     (4),
        .DIV_PHASE (8),
        .HIST_W    (24),
        .DATA_TAP  (7),
        .MAX_BYTES (MAX_BYTES)
    ) dut (
        .ck_1356meg     (clk),
        .rst            (rst),
        .mode_i         (mode_i),
        .relay_in       (relay_in),
        .mod_type_o     (mod_type_o),
        .data_o         (data_o),
        .frame_active_o (frame_active_o),
        .byte_strobe_o  (byte_strobe_o),
        .timeout_err_o  (timeout_err_o)
`ifdef RELAY_FRAME_CNT_EN
        ,
        .frame_cnt_o    (frame_cnt_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [2:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        expq.push_back(e);
    endtask

    task automatic pop_check(input string name, input logic [1:0] kind, input logic [2:0] val);
        ev_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL %s: got unexpected event kind=%0d val=%0h, expected none", name, kind, val);
        end else begin
            e = expq.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                bad++;
                $display("FAIL %s: got kind=%0d val=%0h expected kind=%0d val=%0h",
                         name, kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (byte_strobe_o) pop_check("byte_strobe", EV_STB, 3'd0);
            if (timeout_err_o) pop_check("timeout_err", EV_TMO, 3'd0);
            if (mod_type_o !== prev_mod) begin
                pop_check("mod_type", EV_MOD, mod_type_o);
                prev_mod = mod_type_o;
            end
        end
    end

    // One window = one tick period; exactly one sample tick falls inside it.
    task automatic win();
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            relay_in = v[i];
            win();
        end
    endtask

    task automatic set_mode(input logic [2:0] m);
        mode_i   = m;
        relay_in = 1'b0;
        win();
    endtask

    task automatic reader_frame();
        push_ev(EV_MOD, 3'b100);
        send_bits(32'h0000C0, 24);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_MOD, 3'b011);
        send_bits(32'h0, 16);
    endtask

    initial begin
        rst      = 1'b1;
        mode_i   = 3'b101;
        relay_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mod_type", 32'(mod_type_o), 32'h3);
        check("reset_data", 32'(data_o), 32'h0);
        check("reset_frame_active", 32'(frame_active_o), 32'h0);
        check("reset_strobe", 32'(byte_strobe_o), 32'h0);
        check("reset_timeout", 32'(timeout_err_o), 32'h0);
`ifdef RELAY_FRAME_CNT_EN
        check("reset_frame_cnt", 32'(frame_cnt_o), 32'h0);
`endif
        rst      = 1'b0;
        prev_mod = 3'b011;
        mon_en   = 1'b1;

        // Reader start then byte-aligned 0xC00000 end
        push_ev(EV_MOD, 3'b100);
        send_bits(32'h0000C0, 24);
        check("rd_start_mod", 32'(mod_type_o), 32'h4);
        check("rd_start_active", 32'(frame_active_o), 32'h1);
        check("rd_start_data", 32'(data_o), 32'h1);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_MOD, 3'b011);
        send_bits(32'h0, 16);
        check("rd_end_active", 32'(frame_active_o), 32'h0);

        // Misaligned all-zero history must not end the frame
        push_ev(EV_MOD, 3'b100);
        send_bits(32'h0000C0, 24);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_STB, 3'd0);
        push_ev(EV_MOD, 3'b011);
        send_bits(32'h1F, 5);
        send_bits(32'h0, 24);
        check("misaligned_mod", 32'(mod_type_o), 32'h4);
        check("misaligned_active", 32'(frame_active_o), 32'h1);
        send_bits(32'h0, 3);
        check("aligned_end_mod", 32'(mod_type_o), 32'h3);
`ifdef RELAY_FRAME_CNT_EN
        check("frame_cnt_2", 32'(frame_cnt_o), 32'h2);
`endif

        // Tag role: start, then no end pattern until MAX_BYTES expires
        push_ev(EV_MOD, 3'b001);
        set_mode(3'b110);
        push_ev(EV_MOD, 3'b010);
        send_bits(32'h0000F0, 24);
        check("tag_start_mod", 32'(mod_type_o), 32'h2);
        for (int i = 0; i < MAX_BYTES; i++) push_ev(EV_STB, 3'd0);
        push_ev(EV_TMO, 3'd0);
        push_ev(EV_MOD, 3'b001);
        send_bits(32'hFFFFFFFF, 32);
        check("timeout_mod", 32'(mod_type_o), 32'h1);
        check("timeout_active", 32'(frame_active_o), 32'h0);

        // Drop to passthrough mid-frame, then return to tag role
        push_ev(EV_MOD, 3'b010);
        send_bits(32'h0000F0, 24);
        check("tag_restart_data", 32'(data_o), 32'h1);
        push_ev(EV_MOD, 3'b000);
        mode_i   = 3'b000;
        relay_in = 1'b1;
        #2;
        check("passthru_immediate", 32'(mod_type_o), 32'h0);
        win();
        check("passthru_active", 32'(frame_active_o), 32'h0);
        push_ev(EV_MOD, 3'b001);
        set_mode(3'b110);
        check("tag_return_mod", 32'(mod_type_o), 32'h1);
        check("tag_return_data", 32'(data_o), 32'h0);

        // Third good reader frame, then a frame with the counter at its ceiling
        push_ev(EV_MOD, 3'b011);
        set_mode(3'b101);
        reader_frame();
        check("final_mod", 32'(mod_type_o), 32'h3);
`ifdef RELAY_FRAME_CNT_EN
        check("frame_cnt_3", 32'(frame_cnt_o), 32'h3);
        dut.frame_cnt_q = 16'hFFFF;
`endif
        reader_frame();
`ifdef RELAY_FRAME_CNT_EN
        check("frame_cnt_sat", 32'(frame_cnt_o), 32'hFFFF);
`endif

        for (int i = 0; i < 32 && expq.size() != 0; i++) @(posedge clk);
        check("queue_drain", 32'(expq.size()), 32'h0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
